// File: rtl/gb_patch_loader.sv
// Patch-preset engine: watches per-channel selector fields and writes the
// selected preset back into the OSD status word, one channel at a time.
`timescale 1ns/1ps
module gb_patch_loader #(
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 3,
   parameter int PATCH_W  = 15,
   parameter int GAP      = 2
) (
   input  logic                              clk_sys,
   input  logic                              reset,
   input  logic [CHANNELS*SEL_W-1:0]         sel,
   input  logic                              reload_all,
   input  logic                              tbl_wr,
   input  logic [$clog2(CHANNELS)+SEL_W-1:0] tbl_addr,
   input  logic [PATCH_W-1:0]                tbl_data,
   output logic [PATCH_W-1:0]                patch_data,
   output logic [CHANNELS-1:0]               set_mask,
   output logic                              status_set,
   output logic                              busy
);

   localparam int CH_W  = $clog2(CHANNELS);
   localparam int AW    = CH_W + SEL_W;
   localparam int DEPTH = CHANNELS << SEL_W;
   localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [2:0] S_INIT = 3'd0;
   localparam logic [2:0] S_IDLE = 3'd1;
   localparam logic [2:0] S_READ = 3'd2;
   localparam logic [2:0] S_SET  = 3'd3;
   localparam logic [2:0] S_GAP  = 3'd4;

   logic [2:0]               state;
   logic [CHANNELS-1:0]      pend, chg, clr;
   logic [CHANNELS*SEL_W-1:0] sel_last;
   logic [CH_W-1:0]          rr_ptr, gnt, gnt_q;
   logic                     found;
   logic [GW-1:0]            gap_cnt;
   logic [PATCH_W-1:0]       mem [DEPTH];
   logic [PATCH_W-1:0]       tbl_q;
   logic [AW-1:0]            rd_addr;

   always_comb begin
      chg = '0;
      for (int c = 0; c < CHANNELS; c++)
         chg[c] = sel[c*SEL_W +: SEL_W] != sel_last[c*SEL_W +: SEL_W];
   end

   // Round-robin pick: first pending channel at or after rr_ptr.
   always_comb begin
      int idx;
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < CHANNELS; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= CHANNELS) idx = idx - CHANNELS;
         if (!found && pend[idx]) begin
            found = 1'b1;
            gnt   = CH_W'(idx);
         end
      end
   end

   // The grant clear wins over a same-cycle change: the read uses the live selector.
   assign clr     = (state == S_IDLE && found) ? (CHANNELS'(1) << gnt) : '0;
   assign rd_addr = {gnt, sel[gnt*SEL_W +: SEL_W]};

   always_ff @(posedge clk_sys) begin
      if (tbl_wr) mem[tbl_addr] <= tbl_data;
      tbl_q <= mem[rd_addr];
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state      <= S_INIT;
         pend       <= '0;
         sel_last   <= '0;
         rr_ptr     <= '0;
         gnt_q      <= '0;
         gap_cnt    <= '0;
         patch_data <= '0;
      end else if (state == S_INIT) begin
         // Resample selectors so settings restored at power-up are not reloaded.
         sel_last <= sel;
         state    <= S_IDLE;
      end else begin
         sel_last <= sel;
         pend     <= (pend | chg | {CHANNELS{reload_all}}) & ~clr;
         case (state)
            S_IDLE: if (found) begin
               gnt_q  <= gnt;
               rr_ptr <= (gnt == CH_W'(CHANNELS-1)) ? '0 : gnt + 1'b1;
               state  <= S_READ;
            end
            S_READ: begin
               patch_data <= tbl_q;
               state      <= S_SET;
            end
            S_SET: begin
               gap_cnt <= '0;
               state   <= S_GAP;
            end
            S_GAP: begin
               if (gap_cnt == GW'(GAP-1)) state <= S_IDLE;
               else gap_cnt <= gap_cnt + 1'b1;
            end
            default: state <= S_INIT;
         endcase
      end
   end

   assign status_set = (state == S_SET);
   assign set_mask   = status_set ? (CHANNELS'(1) << gnt_q) : '0;
   assign busy       = (state != S_IDLE) || (|pend);

endmodule

// File: tb/tb_gb_patch_loader.sv
// Scoreboard bench for gb_patch_loader: stimulus pushes expected writebacks,
// a forked monitor pops and compares them on every status_set pulse.
`timescale 1ns/1ps
module tb_gb_patch_loader;
   localparam int CH = 4, SW = 3, PW = 15, GAP = 2;

   logic            clk_sys = 1'b0;
   logic            reset;
   logic [CH*SW-1:0] sel;
   logic            reload_all, tbl_wr;
   logic [4:0]      tbl_addr;
   logic [PW-1:0]   tbl_data;
   logic [PW-1:0]   patch_data;
   logic [CH-1:0]   set_mask;
   logic            status_set, busy;

   gb_patch_loader #(.CHANNELS(CH), .SEL_W(SW), .PATCH_W(PW), .GAP(GAP)) dut (
      .clk_sys(clk_sys), .reset(reset), .sel(sel), .reload_all(reload_all),
      .tbl_wr(tbl_wr), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
      .patch_data(patch_data), .set_mask(set_mask), .status_set(status_set),
      .busy(busy));

   always #5 clk_sys = ~clk_sys;

   typedef struct { logic [CH-1:0] mask; logic [PW-1:0] data; } exp_t;
   exp_t          expq[$];
   int            pulse_cyc[$];
   logic [PW-1:0] tbl_m [CH*8];
   logic [SW-1:0] sel_v [CH];
   int            rr;
   int            n_vec = 0, n_err = 0, cyc = 0, pulses = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic monitor();
      logic prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk_sys);
         cyc++;
         if (reset) begin prev = 1'b0; continue; end
         if (status_set) begin
            pulses++;
            pulse_cyc.push_back(cyc);
            chk("no_back_to_back", prev, 0);
            chk("mask_onehot", $onehot(set_mask), 1);
            chk("pulse_expected", expq.size() > 0, 1);
            if (expq.size() > 0) begin
               e = expq.pop_front();
               chk("set_mask", set_mask, e.mask);
               chk("patch_data", patch_data, e.data);
            end
         end else if (set_mask != '0) chk("mask_idle_zero", set_mask, 0);
         prev = status_set;
      end
   endtask

   task automatic tick(); @(posedge clk_sys); #1; endtask

   task automatic drive_sel();
      for (int c = 0; c < CH; c++) sel[c*SW +: SW] = sel_v[c];
   endtask

   task automatic wr_tbl(int ch, int s, logic [PW-1:0] d);
      tbl_wr = 1'b1; tbl_addr = 5'(ch*8 + s); tbl_data = d;
      tick();
      tbl_wr = 1'b0;
      tbl_m[ch*8 + s] = d;
   endtask

   // Reference: channels made pending together are served in round-robin order.
   task automatic serve(logic [CH-1:0] chmask);
      exp_t e;
      int   c, last;
      last = rr;
      for (int i = 0; i < CH; i++) begin
         c = (rr + i) % CH;
         if (chmask[c]) begin
            e.mask = CH'(1) << c;
            e.data = tbl_m[c*8 + int'(sel_v[c])];
            expq.push_back(e);
            last = c;
         end
      end
      rr = (last + 1) % CH;
   endtask

   task automatic drain();
      int n = 0;
      while ((expq.size() != 0 || busy) && n < 500) begin tick(); n++; end
      chk("drain_queue", expq.size(), 0);
      chk("drain_busy", busy, 0);
   endtask

   task automatic wait_pulse();
      int n = 0;
      do begin @(negedge clk_sys); n++; end while (!status_set && n < 100);
      chk("pulse_seen", status_set, 1);
   endtask

   task automatic change(int c, logic [SW-1:0] v);
      sel_v[c] = v; drive_sel();
   endtask

   initial begin
      int p0, n;
      logic [CH-1:0] m;
      logic          rl;
      fork monitor(); join_none

      reset = 1'b1; reload_all = 1'b0; tbl_wr = 1'b0; tbl_addr = '0; tbl_data = '0;
      for (int c = 0; c < CH; c++) sel_v[c] = SW'(c);
      drive_sel();
      for (int i = 0; i < CH*8; i++) tbl_m[i] = '0;
      rr = 0;
      repeat (3) tick();
      chk("rst_status_set", status_set, 0);
      chk("rst_set_mask", set_mask, 0);
      chk("rst_patch_data", patch_data, 0);
      chk("rst_busy", busy, 1);
      reset = 1'b0;
      repeat (2) tick();
      chk("busy_after_init", busy, 0);
      p0 = pulses;
      repeat (100) tick();
      chk("quiet_after_reset", pulses - p0, 0);

      for (int i = 0; i < CH*8; i++) wr_tbl(i / 8, i % 8, PW'($urandom));
      wr_tbl(1, 2, 15'h1A5A);

      // Latency: ch1 0 -> 2 with nothing else pending.
      change(1, 3'd0); serve(4'b0010); drain();
      change(3, sel_v[3] + 3'd1); serve(4'b1000); drain();
      change(1, 3'd2); serve(4'b0010);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk_sys);
         chk($sformatf("latency_k+%0d", j), status_set, (j == 3) ? 1 : 0);
      end
      tick(); drain();

      // All four channels change in the same cycle.
      for (int c = 0; c < CH; c++) sel_v[c] = sel_v[c] + SW'($urandom_range(1, 7));
      drive_sel(); serve(4'b1111); drain();
      n = pulse_cyc.size();
      for (int i = 1; i < 4; i++)
         chk("pulse_spacing", pulse_cyc[n-4+i] - pulse_cyc[n-5+i], 3 + GAP);

      // Two quick changes collapse into one load using the last value.
      if (sel_v[2] != 3'd1) begin change(2, 3'd1); serve(4'b0100); drain(); end
      p0 = pulses;
      change(2, 3'd2); tick();
      change(2, 3'd3); serve(4'b0100); drain();
      chk("collapse_one_pulse", pulses - p0, 1);

      // reload_all while ch3 sits in SET.
      change(3, sel_v[3] + 3'd2); serve(4'b1000);
      wait_pulse();
      chk("reload_ch3_in_set", set_mask, 4'b1000);
      reload_all = 1'b1;
      @(posedge clk_sys); #1 reload_all = 1'b0;
      serve(4'b1111); drain();

      // Randomised bursts of simultaneous changes, some with reload_all.
      for (int it = 0; it < 25; it++) begin
         if ($urandom_range(0, 1) == 1)
            wr_tbl($urandom_range(0, CH-1), $urandom_range(0, 7), PW'($urandom));
         m  = CH'($urandom_range(1, 15));
         rl = ($urandom_range(0, 3) == 0);
         for (int c = 0; c < CH; c++)
            if (m[c]) sel_v[c] = sel_v[c] + SW'($urandom_range(1, 7));
         drive_sel(); reload_all = rl;
         tick(); reload_all = 1'b0;
         serve(rl ? 4'b1111 : m);
         repeat ($urandom_range(0, 3)) tick();
         drain();
      end

      // Reset during GAP with ch0 pending: the pending load is dropped.
      change(2, sel_v[2] + 3'd1); serve(4'b0100);
      wait_pulse();
      change(0, sel_v[0] + 3'd1);
      @(negedge clk_sys);
      chk("gap_busy_pending", busy, 1);
      #2 reset = 1'b1;
      #1 chk("gap_reset_status_set", status_set, 0);
      expq.delete();
      repeat (2) tick();
      reset = 1'b0; rr = 0;
      p0 = pulses;
      repeat (50) tick();
      chk("no_retry_after_reset", pulses - p0, 0);

      // Reset in SET drops status_set asynchronously.
      change(1, sel_v[1] + 3'd1); serve(4'b0010);
      wait_pulse();
      #2 reset = 1'b1;
      #1 chk("set_reset_async_drop", status_set, 0);
      chk("set_reset_mask_zero", set_mask, 0);
      expq.delete();
      repeat (2) tick();
      reset = 1'b0; rr = 0;
      repeat (3) tick();
      change(3, sel_v[3] + 3'd1); serve(4'b1000); drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
